// File: rtl/pll_dri_reconfig_ctrl_if.sv
// Host, DRI and PLL-pin bundle for pll_dri_reconfig_ctrl.
// master = system control / PF_CCC side, slave = the reconfiguration sequencer.
interface pll_dri_reconfig_ctrl_if #(
  parameter int DEPTH = 8
);
  logic                         cfg_wr_en;
  logic [8:0]                   cfg_addr;
  logic [31:0]                  cfg_data;
  logic                         cfg_full;
  logic [$clog2(DEPTH+1)-1:0]   cfg_count;
  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         err;
  logic [1:0]                   err_code;
  logic [10:0]                  dri_ctrl;
  logic [32:0]                  dri_wdata;
  logic [32:0]                  dri_rdata;
  logic                         dri_interrupt;
  logic                         pll_powerdown_n;
  logic                         pll_lock;
  logic                         pll_locked;

  modport master (
    output cfg_wr_en, cfg_addr, cfg_data, start, dri_rdata, dri_interrupt, pll_lock,
    input  cfg_full, cfg_count, busy, done, err, err_code, dri_ctrl, dri_wdata,
           pll_powerdown_n, pll_locked
  );

  modport slave (
    input  cfg_wr_en, cfg_addr, cfg_data, start, dri_rdata, dri_interrupt, pll_lock,
    output cfg_full, cfg_count, busy, done, err, err_code, dri_ctrl, dri_wdata,
           pll_powerdown_n, pll_locked
  );
endinterface

// File: rtl/pll_dri_reconfig_ctrl.sv
// Queued DRI write sequencer for PLL reconfiguration: powerdown, writes, release, relock.
// Define PLL_DRI_READBACK_EN to verify every write with a DRI readback.
module pll_dri_reconfig_ctrl #(
  parameter int DEPTH        = 8,
  parameter int PD_CYCLES    = 16,
  parameter int ACK_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input logic                    dri_clk,
  input logic                    dri_arst,
  pll_dri_reconfig_ctrl_if.slave bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int QW   = $clog2(DEPTH + 1);
  localparam int TMAX = (LOCK_TIMEOUT > ACK_TIMEOUT)
                        ? ((LOCK_TIMEOUT > PD_CYCLES) ? LOCK_TIMEOUT : PD_CYCLES)
                        : ((ACK_TIMEOUT > PD_CYCLES) ? ACK_TIMEOUT : PD_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [QW-1:0] Q_FULL    = QW'(DEPTH);
  localparam logic [QW-1:0] Q_ONE     = QW'(1);
  localparam logic [TW-1:0] PD_LAST   = TW'(PD_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PD,
    S_WR_ISSUE,
    S_WR_WAIT,
`ifdef PLL_DRI_READBACK_EN
    S_RD_ISSUE,
    S_RD_WAIT,
`endif
    S_WR_DONE,
    S_RELEASE,
    S_LOCK_WAIT
  } state_t;

  state_t         state;
  logic [TW-1:0]  tmr;
  logic [40:0]    queue_mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  rd_ptr_next;
  logic [QW-1:0]  q_count;
  logic           busy;
  logic           done;
  logic           err;
  logic [1:0]     err_code;
  logic [10:0]    dri_ctrl;
  logic [31:0]    wdata;
  logic           pwdn_n;
  logic           lock_meta;
  logic           lock_sync;
  logic           push;
  logic           dri_ack;
  logic [40:0]    head_entry;
  logic [40:0]    next_entry;
  logic           err_hit;
  logic [1:0]     err_hit_code;

  assign push        = bus.cfg_wr_en && (q_count != Q_FULL) && !busy;
  assign dri_ack     = bus.dri_rdata[32];
  assign rd_ptr_next = rd_ptr + 1'b1;
  assign head_entry  = queue_mem[rd_ptr];
  assign next_entry  = queue_mem[rd_ptr_next];

  assign bus.cfg_full        = (q_count == Q_FULL);
  assign bus.cfg_count       = q_count;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.err             = err;
  assign bus.err_code        = err_code;
  assign bus.dri_ctrl        = dri_ctrl;
  assign bus.dri_wdata       = {1'b0, wdata};
  assign bus.pll_powerdown_n = pwdn_n;
  assign bus.pll_locked      = lock_sync;

`ifndef PLL_DRI_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^bus.dri_rdata[31:0];
`endif

  always_ff @(posedge dri_clk) begin
    if (push) queue_mem[wr_ptr] <= {bus.cfg_addr, bus.cfg_data};
  end

  always_ff @(posedge dri_clk or posedge dri_arst) begin
    if (dri_arst) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= bus.pll_lock;
      lock_sync <= lock_meta;
    end
  end

  // An interrupt outranks an ack or timeout seen in the same cycle.
  always_comb begin
    err_hit      = 1'b0;
    err_hit_code = 2'b00;
    if (state != S_IDLE && bus.dri_interrupt) begin
      err_hit      = 1'b1;
      err_hit_code = 2'b11;
    end else begin
      case (state)
        S_WR_WAIT: begin
          if (!dri_ack && tmr == ACK_LAST) begin
            err_hit      = 1'b1;
            err_hit_code = 2'b01;
          end
        end
`ifdef PLL_DRI_READBACK_EN
        S_RD_WAIT: begin
          if (dri_ack && bus.dri_rdata[31:0] != wdata) begin
            err_hit      = 1'b1;
            err_hit_code = 2'b11;
          end else if (!dri_ack && tmr == ACK_LAST) begin
            err_hit      = 1'b1;
            err_hit_code = 2'b01;
          end
        end
`endif
        S_LOCK_WAIT: begin
          if (!lock_sync && tmr == LOCK_LAST) begin
            err_hit      = 1'b1;
            err_hit_code = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge dri_clk or posedge dri_arst) begin
    if (dri_arst) begin
      state    <= S_IDLE;
      tmr      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      dri_ctrl <= '0;
      wdata    <= '0;
      pwdn_n   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        q_count <= q_count + 1'b1;
      end
      // Any failure aborts the sequence, drops pending writes and lets the PLL run again.
      if (err_hit) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        err      <= 1'b1;
        err_code <= err_hit_code;
        pwdn_n   <= 1'b1;
        dri_ctrl <= '0;
        q_count  <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              err      <= 1'b0;
              err_code <= 2'b00;
              busy     <= 1'b1;
              pwdn_n   <= 1'b0;
              tmr      <= '0;
              state    <= S_PD;
            end
          end
          S_PD: begin
            if (tmr == PD_LAST) begin
              if (q_count == '0) begin
                state <= S_RELEASE;
              end else begin
                dri_ctrl <= {2'b11, head_entry[40:32]};
                wdata    <= head_entry[31:0];
                state    <= S_WR_ISSUE;
              end
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          S_WR_ISSUE: begin
            dri_ctrl <= '0;
            tmr      <= '0;
            state    <= S_WR_WAIT;
          end
          S_WR_WAIT: begin
            if (dri_ack) begin
`ifdef PLL_DRI_READBACK_EN
              dri_ctrl <= {2'b10, head_entry[40:32]};
              state    <= S_RD_ISSUE;
`else
              state    <= S_WR_DONE;
`endif
            end else if (tmr != '1) begin
              tmr <= tmr + 1'b1;
            end
          end
`ifdef PLL_DRI_READBACK_EN
          S_RD_ISSUE: begin
            dri_ctrl <= '0;
            tmr      <= '0;
            state    <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (dri_ack) begin
              state <= S_WR_DONE;
            end else if (tmr != '1) begin
              tmr <= tmr + 1'b1;
            end
          end
`endif
          // The entry leaves the queue only once its write is confirmed.
          S_WR_DONE: begin
            rd_ptr  <= rd_ptr_next;
            q_count <= q_count - 1'b1;
            if (q_count > Q_ONE) begin
              dri_ctrl <= {2'b11, next_entry[40:32]};
              wdata    <= next_entry[31:0];
              state    <= S_WR_ISSUE;
            end else begin
              state <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            pwdn_n <= 1'b1;
            tmr    <= '0;
            state  <= S_LOCK_WAIT;
          end
          S_LOCK_WAIT: begin
            if (lock_sync) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (tmr != '1) begin
              tmr <= tmr + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/pll_dri_reconfig_ctrl.md
Name: pll_dri_reconfig_ctrl

Overview:
Sequencer for run-time reconfiguration of the fabric PLL through its DRI register port. Host loads a list of register writes into an internal queue, then pulses START. The block then powers the PLL down, issues each DRI write with ack/timeout checking, releases powerdown and waits for lock. Sits between the system control logic and the PF_CCC DRI/POWERDOWN/LOCK pins, on the DRI clock domain.

Parameters:
DEPTH, 8, entries in the write queue (power of 2, 2..32)
PD_CYCLES, 16, clocks PLL_POWERDOWN_N is held low before the first DRI write
ACK_TIMEOUT, 64, max clocks from write issue to DRI ack
LOCK_TIMEOUT, 4096, max clocks from powerdown release to synced lock

Ports:
DRI_CLK  in  1  sole clock; all logic on rising edge
DRI_ARST  in  1  reset; one clock; reset is asynchronous and active-high
CFG_WR_EN  in  1  push {CFG_ADDR, CFG_DATA} into queue
CFG_ADDR  in  9  DRI register address
CFG_DATA  in  32  DRI register write data
CFG_FULL  out  1  queue full
CFG_COUNT  out  $clog2(DEPTH+1)  queued entries
START  in  1  single-cycle pulse: begin sequence
BUSY  out  1  sequence in progress
DONE  out  1  one-cycle pulse on successful completion
ERR  out  1  sticky error flag, cleared by next accepted START
ERR_CODE  out  2  01 ack timeout, 10 lock timeout, 11 DRI interrupt/readback mismatch
DRI_CTRL  out  11  [10] strobe, [9] 1=write/0=read, [8:0] address
DRI_WDATA  out  33  {1'b0, data}
DRI_RDATA  in  33  [32] ack, [31:0] read data
DRI_INTERRUPT  in  1  DRI error indication
PLL_POWERDOWN_N  out  1  PLL powerdown, active-low
PLL_LOCK  in  1  raw PLL lock (asynchronous)
PLL_LOCKED  out  1  PLL_LOCK after 2-flop synchroniser

Behaviour:
- Reset: all outputs 0 except PLL_POWERDOWN_N=1; queue emptied; FSM=IDLE; sync flops 0.
- Queue: push on CFG_WR_EN when !CFG_FULL and !BUSY; push when full or BUSY dropped, no state change. Pops only in WR_DONE.
- FSM: IDLE -> PD -> WR_ISSUE -> WR_WAIT -> (next entry: WR_ISSUE | queue empty: RELEASE) -> LOCK_WAIT -> IDLE.
- IDLE: START accepted -> ERR=0, ERR_CODE=0, BUSY=1, PLL_POWERDOWN_N=0 on next edge, enter PD. START while BUSY ignored.
- PD: count PD_CYCLES clocks; then WR_ISSUE, or RELEASE if queue empty (plain PLL reset cycle).
- WR_ISSUE: DRI_CTRL={1,1,addr} for exactly one cycle; DRI_WDATA driven with entry data and held through WR_WAIT.
- WR_WAIT: DRI_CTRL=0; ack sampled from first cycle after issue; DRI_RDATA[32]=1 -> pop entry, continue. ACK_TIMEOUT clocks without ack -> error 01.
- RELEASE: PLL_POWERDOWN_N=1, zero lock counter, enter LOCK_WAIT.
- LOCK_WAIT: PLL_LOCKED=1 -> DONE pulse, BUSY=0, IDLE. Counter reaches LOCK_TIMEOUT -> error 10.
- DRI_INTERRUPT=1 in any non-IDLE state -> error 11 (takes priority over same-cycle ack).
- Error handling: ERR=1, ERR_CODE set, queue flushed, PLL_POWERDOWN_N=1, DRI_CTRL=0, BUSY=0, IDLE; no DONE.
- DRI_ARST mid-sequence: immediate return to reset state; powerdown released.
- Counters saturate; no wrap-around.

Optional Feature:
PLL_DRI_READBACK_EN: when defined, after each write ack the FSM inserts RD_ISSUE (DRI_CTRL={1,0,addr}, one cycle) and RD_WAIT (same ack/timeout rules); DRI_RDATA[31:0] != written data -> error 11; pop only after matching readback. When undefined, no read states exist and DRI_CTRL[9] is always 1 when strobed.

Test Plan:
- Push 3 entries (addr 0x004/0x008/0x00C), START, ack 2 clocks after each strobe, lock 100 clocks after release -> POWERDOWN_N low exactly 16+ clocks, 3 write strobes in order, DONE one pulse, ERR=0, CFG_COUNT=0.
- No ack for entry 2 -> ERR=1, ERR_CODE=01 at 64 clocks after strobe, POWERDOWN_N=1, queue flushed, no DONE.
- PLL_LOCK held 0 -> ERR_CODE=10 at 4096 clocks after release; next START clears ERR.
- Push 9 entries with DEPTH=8 -> CFG_FULL=1, CFG_COUNT=8, 9th dropped; pushes and START during BUSY ignored.
- Empty queue START -> PD 16 clocks, no DRI strobes, relock, DONE.
- DRI_ARST pulsed during WR_WAIT -> all outputs at reset values, POWERDOWN_N=1; readback build: return wrong data -> ERR_CODE=11.
